// File: rtl/control_unit.sv
// Multicycle MIPS-style control FSM: 4-bit state register with outputs decoded from state.
// Optional overflow trap (R-type add/sub, addi) enabled by defining CONTROL_OVERFLOW_TRAP_EN.
module control_unit (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic [5:0] Operation,
  input  logic [5:0] Funct,
  input  logic       ALU_zero,
  input  logic       ALU_overflow,
  output logic       regs_reset,
  output logic       pc_load,
  output logic       mem_write,
  output logic       instReg_load,
  output logic       a_load,
  output logic       b_load,
  output logic       ALUout_load,
  output logic [2:0] ALU_select,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    StRst       = 4'd0,
    StFetch     = 4'd1,
    StFetchWait = 4'd2,
    StDecode    = 4'd3,
    StMemAddr   = 4'd4,
    StMemRd     = 4'd5,
    StMemWb     = 4'd6,
    StMemWr     = 4'd7,
    StRExec     = 4'd8,
    StRWb       = 4'd9,
    StBranch    = 4'd10,
    StJump      = 4'd11,
    StAddiExec  = 4'd12,
    StAddiWb    = 4'd13,
    StExc       = 4'd14
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnXor = 6'h26;

  state_e state_q, state_d;
  logic   funct_valid;
  logic   funct_arith;

  assign funct_valid = (Funct == FnAdd) || (Funct == FnSub) ||
                       (Funct == FnAnd) || (Funct == FnXor);
  assign funct_arith = (Funct == FnAdd) || (Funct == FnSub);

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StRst;
    case (state_q)
      StRst:       state_d = StFetch;
      StFetch:     state_d = StFetchWait;
      StFetchWait: state_d = StDecode;
      StDecode: begin
        case (Operation)
          OpLw, OpSw:    state_d = StMemAddr;
          OpRType:       state_d = funct_valid ? StRExec : StFetch;
          OpBeq, OpBne:  state_d = StBranch;
          OpJ:           state_d = StJump;
          OpAddi:        state_d = StAddiExec;
          default:       state_d = StFetch;
        endcase
      end
      StMemAddr:   state_d = (Operation == OpLw) ? StMemRd : StMemWr;
      StMemRd:     state_d = StMemWb;
      StMemWb:     state_d = StFetch;
      StMemWr:     state_d = StFetch;
`ifdef CONTROL_OVERFLOW_TRAP_EN
      StRExec:     state_d = (ALU_overflow && funct_arith) ? StExc : StRWb;
      StAddiExec:  state_d = ALU_overflow ? StExc : StAddiWb;
`else
      StRExec:     state_d = StRWb;
      StAddiExec:  state_d = StAddiWb;
`endif
      StRWb:       state_d = StFetch;
      StBranch:    state_d = StFetch;
      StJump:      state_d = StFetch;
      StAddiWb:    state_d = StFetch;
      StExc:       state_d = StFetch;
      default:     state_d = StRst;
    endcase
  end

`ifndef CONTROL_OVERFLOW_TRAP_EN
  logic unused_overflow;
  logic unused_funct_arith;
  assign unused_overflow    = ALU_overflow;
  assign unused_funct_arith = funct_arith;
`endif

  always_comb begin
    regs_reset   = 1'b0;
    pc_load      = 1'b0;
    mem_write    = 1'b0;
    instReg_load = 1'b0;
    a_load       = 1'b0;
    b_load       = 1'b0;
    ALUout_load  = 1'b0;
    ALU_select   = 3'b000;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    PCSource     = 2'b00;
    IorD         = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    case (state_q)
      StRst:       regs_reset = 1'b1;
      StFetch:     IorD = 1'b0;
      StFetchWait: begin
        instReg_load = 1'b1;
        pc_load      = 1'b1;
        ALUSrcB      = 2'b01;
        ALU_select   = 3'b001;
      end
      StDecode: begin
        // Speculatively compute the branch target into ALUout.
        a_load      = 1'b1;
        b_load      = 1'b1;
        ALUout_load = 1'b1;
        ALUSrcB     = 2'b11;
        ALU_select  = 3'b001;
      end
      StMemAddr, StAddiExec: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_select  = 3'b001;
        ALUout_load = 1'b1;
      end
      StMemRd:     IorD = 1'b1;
      StMemWb: begin
        IorD     = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      StMemWr: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
      end
      StRExec: begin
        ALUSrcA     = 1'b1;
        ALUout_load = 1'b1;
        case (Funct)
          FnAdd:   ALU_select = 3'b001;
          FnSub:   ALU_select = 3'b010;
          FnAnd:   ALU_select = 3'b011;
          FnXor:   ALU_select = 3'b110;
          default: ALU_select = 3'b000;
        endcase
      end
      StRWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA    = 1'b1;
        ALU_select = 3'b010;
        PCSource   = 2'b01;
        pc_load    = ((Operation == OpBeq) && ALU_zero) || ((Operation == OpBne) && !ALU_zero);
      end
      StJump: begin
        PCSource = 2'b10;
        pc_load  = 1'b1;
      end
      StAddiWb:    RegWrite = 1'b1;
      StExc: begin
        PCSource = 2'b11;
        pc_load  = 1'b1;
      end
      default: ;
    endcase
    // Reset masks every state-changing enable immediately, even mid-instruction.
    if (!reset_n) begin
      regs_reset   = 1'b1;
      pc_load      = 1'b0;
      mem_write    = 1'b0;
      RegWrite     = 1'b0;
      instReg_load = 1'b0;
      a_load       = 1'b0;
      b_load       = 1'b0;
      ALUout_load  = 1'b0;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: per-instruction state paths and per-state output rules
// are modelled from the instruction set, checked every cycle, plus literal directed checks.
module tb_control_unit;

  logic       Clk;
  logic       reset_n;
  logic [5:0] Operation;
  logic [5:0] Funct;
  logic       ALU_zero;
  logic       ALU_overflow;
  logic       regs_reset, pc_load, mem_write, instReg_load, a_load, b_load, ALUout_load;
  logic [2:0] ALU_select;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       IorD, RegWrite, RegDst, MemtoReg;
  logic [3:0] State;

  control_unit dut (
    .Clk          (Clk),
    .reset_n      (reset_n),
    .Operation    (Operation),
    .Funct        (Funct),
    .ALU_zero     (ALU_zero),
    .ALU_overflow (ALU_overflow),
    .regs_reset   (regs_reset),
    .pc_load      (pc_load),
    .mem_write    (mem_write),
    .instReg_load (instReg_load),
    .a_load       (a_load),
    .b_load       (b_load),
    .ALUout_load  (ALUout_load),
    .ALU_select   (ALU_select),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .PCSource     (PCSource),
    .IorD         (IorD),
    .RegWrite     (RegWrite),
    .RegDst       (RegDst),
    .MemtoReg     (MemtoReg),
    .State        (State)
  );

`ifdef CONTROL_OVERFLOW_TRAP_EN
  localparam bit Trap      = 1'b1;
  localparam int ExpRAfter = 14;
  localparam int ExpRWrite = 0;
`else
  localparam bit Trap      = 1'b0;
  localparam int ExpRAfter = 9;
  localparam int ExpRWrite = 1;
`endif

  typedef int int_q_t[$];

  int checks;
  int failures;
  int exp_st;
  bit chk_en;
  int obs_st[$];
  bit obs_pc[$];
  bit obs_mw[$];
  bit obs_rw[$];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Full sequence of state codes visited by one instruction, starting at FETCH.
  function automatic int_q_t build_path(logic [5:0] op, logic [5:0] fn, logic ovf);
    int_q_t p;
    bit r_ok;
    bit arith;
    p = '{1, 2, 3};
    r_ok  = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h26);
    arith = (fn == 6'h20) || (fn == 6'h22);
    if (op == 6'h23) p = '{1, 2, 3, 4, 5, 6};
    else if (op == 6'h2B) p = '{1, 2, 3, 4, 7};
    else if (op == 6'h00 && r_ok) p = '{1, 2, 3, 8, (Trap && ovf && arith) ? 14 : 9};
    else if (op == 6'h08) p = '{1, 2, 3, 12, (Trap && ovf) ? 14 : 13};
    else if (op == 6'h04 || op == 6'h05) p = '{1, 2, 3, 10};
    else if (op == 6'h02) p = '{1, 2, 3, 11};
    return p;
  endfunction

  // Output vector a state must present, in the order of the compare concatenation.
  function automatic logic [18:0] exp_out(int st, logic [5:0] op, logic [5:0] fn, logic z,
                                          logic rn);
    logic rr, pl, mw, il, al, bl, ol, sa, io, rw, rd, mr;
    logic [2:0] sel;
    logic [1:0] sb, ps;
    {rr, pl, mw, il, al, bl, ol, sa, io, rw, rd, mr} = '0;
    sel = 3'b000; sb = 2'b00; ps = 2'b00;
    case (st)
      0:  rr = 1'b1;
      2:  begin il = 1'b1; pl = 1'b1; sb = 2'b01; sel = 3'b001; end
      3:  begin al = 1'b1; bl = 1'b1; ol = 1'b1; sb = 2'b11; sel = 3'b001; end
      4, 12: begin sa = 1'b1; sb = 2'b10; sel = 3'b001; ol = 1'b1; end
      5:  io = 1'b1;
      6:  begin io = 1'b1; rw = 1'b1; mr = 1'b1; end
      7:  begin io = 1'b1; mw = 1'b1; end
      8:  begin
        sa = 1'b1; ol = 1'b1;
        if (fn == 6'h20) sel = 3'b001;
        else if (fn == 6'h22) sel = 3'b010;
        else if (fn == 6'h24) sel = 3'b011;
        else if (fn == 6'h26) sel = 3'b110;
      end
      9:  begin rw = 1'b1; rd = 1'b1; end
      10: begin
        sa = 1'b1; sel = 3'b010; ps = 2'b01;
        pl = (op == 6'h04 && z) || (op == 6'h05 && !z);
      end
      11: begin ps = 2'b10; pl = 1'b1; end
      13: rw = 1'b1;
      14: begin ps = 2'b11; pl = 1'b1; end
      default: ;
    endcase
    if (!rn) begin
      rr = 1'b1; pl = 1'b0; mw = 1'b0; rw = 1'b0;
      il = 1'b0; al = 1'b0; bl = 1'b0; ol = 1'b0;
    end
    return {rr, pl, mw, il, al, bl, ol, sel, sa, sb, ps, io, rw, rd, mr};
  endfunction

  always @(negedge Clk) begin
    if (chk_en) begin
      logic [18:0] got, want;
      checks++;
      if (int'(State) != exp_st || $isunknown(State)) begin
        failures++;
        $display("FAIL state t=%0t got=%0d want=%0d", $time, State, exp_st);
      end
      got  = {regs_reset, pc_load, mem_write, instReg_load, a_load, b_load, ALUout_load,
              ALU_select, ALUSrcA, ALUSrcB, PCSource, IorD, RegWrite, RegDst, MemtoReg};
      want = exp_out(exp_st, Operation, Funct, ALU_zero, reset_n);
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL outputs t=%0t st=%0d got=%b want=%b", $time, exp_st, got, want);
      end
    end
  end

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic capture();
    obs_st.push_back(int'(State));
    obs_pc.push_back(pc_load);
    obs_mw.push_back(mem_write);
    obs_rw.push_back(RegWrite);
  endtask

  // Runs one instruction from FETCH; zf<0 randomizes ALU_zero, rst_in=-2 picks a random
  // reset point, -1 means none. A reset aborts the instruction and lands back in RST.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                           input int zf, input int rst_in);
    int_q_t path;
    int rst_at;
    path   = build_path(op, fn, ovf);
    rst_at = rst_in;
    if (rst_at == -2)
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, path.size() - 1)) : -1;
    obs_st.delete(); obs_pc.delete(); obs_mw.delete(); obs_rw.delete();
    Operation = op;
    Funct     = fn;
    for (int k = 0; k < path.size(); k++) begin
      ALU_zero     = (zf < 0) ? 1'($urandom_range(0, 1)) : (zf != 0);
      ALU_overflow = (k == 3) ? ovf : 1'($urandom_range(0, 1));
      reset_n      = (k == rst_at) ? 1'b0 : 1'b1;
      exp_st       = path[k];
      @(negedge Clk);
      capture();
      @(posedge Clk);
      #1;
      if (k == rst_at) begin
        reset_n = 1'b1;
        exp_st  = 0;
        @(negedge Clk);
        capture();
        @(posedge Clk);
        #1;
        break;
      end
    end
  endtask

  initial begin
    int lw_exp[6];
    int r_exp[5];
    logic [5:0] ops[10];
    logic [5:0] fns[4];
    checks = 0; failures = 0; chk_en = 1'b0; exp_st = 0;
    reset_n = 1'b0; Operation = 6'h00; Funct = 6'h00; ALU_zero = 1'b0; ALU_overflow = 1'b0;
    lw_exp = '{1, 2, 3, 4, 5, 6};
    r_exp  = '{1, 2, 3, 8, ExpRAfter};
    ops    = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3F, 6'h11};
    fns    = '{6'h20, 6'h22, 6'h24, 6'h26};

    // Two edges with reset low, then release.
    @(posedge Clk); #1;
    chk_en = 1'b1;
    @(negedge Clk);
    lit("rst_state_a", int'(State), 0);
    @(posedge Clk); #1;
    reset_n = 1'b1;
    @(negedge Clk);
    lit("rst_state_b", int'(State), 0);
    lit("rst_regs_reset", int'(regs_reset), 1);
    @(posedge Clk); #1;

    run_instr(6'h23, 6'h00, 1'b0, -1, -1);
    lit("lw_len", obs_st.size(), 6);
    for (int i = 0; i < 6; i++) lit($sformatf("lw_state%0d", i), obs_st[i], lw_exp[i]);
    lit("first_pc_load_fetch", int'(obs_pc[0]), 0);
    lit("first_pc_load_wait", int'(obs_pc[1]), 1);
    lit("lw_rw_memaddr", int'(obs_rw[3]), 0);
    lit("lw_rw_memwb", int'(obs_rw[5]), 1);

    run_instr(6'h00, 6'h20, 1'b1, -1, -1);
    for (int i = 0; i < 5; i++) lit($sformatf("add_ovf_state%0d", i), obs_st[i], r_exp[i]);
    lit("add_ovf_regwrite", int'(obs_rw[4]), ExpRWrite);

    run_instr(6'h04, 6'h00, 1'b0, 0, -1);
    lit("beq_nz_pc_load", int'(obs_pc[3]), 0);
    run_instr(6'h04, 6'h00, 1'b0, 1, -1);
    lit("beq_z_pc_load", int'(obs_pc[3]), 1);

    run_instr(6'h2B, 6'h00, 1'b0, -1, 4);
    lit("sw_rst_len", obs_st.size(), 6);
    lit("sw_rst_in_memwr", obs_st[4], 7);
    lit("sw_rst_mem_write", int'(obs_mw[4]), 0);
    lit("sw_rst_next_state", obs_st[5], 0);

    run_instr(6'h3F, 6'h00, 1'b0, -1, -1);
    lit("nop_len", obs_st.size(), 3);
    lit("nop_decode", obs_st[2], 3);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 9)];
      if (op == 6'h11) op = 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 4) < 4) ? fns[$urandom_range(0, 3)] : 6'($urandom_range(0, 63));
      run_instr(op, fn, 1'($urandom_range(0, 1)), -1, -2);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
- No parameters.
- REQ-001 SHALL have a single clock; reset is synchronous and active-low.
- REQ-002 Clk  in  1  system clock; all state updates on rising edge.
- REQ-003 reset_n  in  1  synchronous active-low reset.
- REQ-004 Operation  in  6  opcode field (instruction[31:26]) from instruction register.
- REQ-005 Funct  in  6  function field (instruction[5:0]).
- REQ-006 ALU_zero  in  1  ALU result equals zero.
- REQ-007 ALU_overflow  in  1  ALU arithmetic overflow.
- REQ-008 regs_reset  out  1  drives pc/instReg/a/b/ALUout reset ports.
- REQ-009 pc_load  out  1  PC load enable.
- REQ-010 mem_write  out  1  memory write enable.
- REQ-011 instReg_load  out  1  instruction register load enable.
- REQ-012 a_load  out  1  A register load enable.
- REQ-013 b_load  out  1  B register load enable.
- REQ-014 ALUout_load  out  1  ALUout register load enable.
- REQ-015 ALU_select  out  3  ALU operation: 000 pass A, 001 add, 010 sub, 011 and, 110 xor.
- REQ-016 ALUSrcA  out  1  0 PC, 1 A.
- REQ-017 ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- REQ-018 PCSource  out  2  00 ALU result, 01 ALUout, 10 jump target, 11 exception vector 0x0000_0080.
- REQ-019 IorD  out  1  memory address: 0 PC, 1 ALUout.
- REQ-020 RegWrite, RegDst, MemtoReg  out  1 each  register-file write enable, dest (0 rt, 1 rd), data (0 ALUout, 1 memory).
- REQ-021 State  out  4  current state code (debug).

Function
- REQ-022 SHALL be a 4-bit state register; outputs decoded from state, except pc_load in BRANCH, which also depends on ALU_zero. Unlisted outputs are 0.
- REQ-023 States/codes: RST 0, FETCH 1, FETCH_WAIT 2, DECODE 3, MEM_ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, R_EXEC 8, R_WB 9, BRANCH 10, JUMP 11, ADDI_EXEC 12, ADDI_WB 13, EXC 14. Code 15 SHALL go to RST.
- REQ-024 RST: regs_reset=1 -> FETCH.
- REQ-025 FETCH: IorD=0, no loads (synchronous memory read issued) -> FETCH_WAIT.
- REQ-026 FETCH_WAIT: instReg_load=1, pc_load=1, ALUSrcA=0, ALUSrcB=01, ALU_select=001, PCSource=00 -> DECODE.
- REQ-027 DECODE: a_load=b_load=ALUout_load=1, ALUSrcA=0, ALUSrcB=11, ALU_select=001 (branch target).
  - Opcode 0x23/0x2B -> MEM_ADDR; 0x00 with Funct 0x20/0x22/0x24/0x26 -> R_EXEC; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDI_EXEC.
  - Any other opcode/funct -> FETCH (no-op).
- REQ-028 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALU_select=001, ALUout_load=1 -> MEM_RD if 0x23, else MEM_WR.
- REQ-029 MEM_RD: IorD=1 -> MEM_WB. MEM_WB: IorD=1, RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- REQ-030 MEM_WR: IorD=1, mem_write=1 -> FETCH.
- REQ-031 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUout_load=1, ALU_select from Funct (0x20->001, 0x22->010, 0x24->011, 0x26->110) -> R_WB. R_WB: RegWrite=1, RegDst=1 -> FETCH.
- REQ-032 ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALU_select=001, ALUout_load=1 -> ADDI_WB. ADDI_WB: RegWrite=1, RegDst=0 -> FETCH.
- REQ-033 BRANCH: ALUSrcA=1, ALUSrcB=00, ALU_select=010, PCSource=01; pc_load=(0x04 & ALU_zero)|(0x05 & !ALU_zero) -> FETCH.
- REQ-034 JUMP: PCSource=10, pc_load=1 -> FETCH.
- REQ-035 Cycle counts, FETCH to FETCH inclusive: lw 6, sw/R/addi 5, beq/bne/j 4.

Reset
- REQ-036 reset_n=0 at a rising edge SHALL force State to RST, regardless of current state.
- REQ-037 While reset_n=0, pc_load, mem_write, RegWrite, instReg_load and all *_load outputs SHALL be combinationally forced to 0, even mid-instruction, and regs_reset forced to 1.

Configuration
- REQ-038 Macro CONTROL_OVERFLOW_TRAP_EN.
  - Defined: ALU_overflow=1 in R_EXEC (add/sub only) or ADDI_EXEC -> EXC instead of the writeback state. EXC: PCSource=11, pc_load=1 -> FETCH; no RegWrite.
  - Undefined: ALU_overflow is ignored and EXC is unreachable.

Verification
- REQ-039 reset_n=0 for 2 cycles, then 1 -> State 0,0,1,2,3; regs_reset=1 only in RST; first pc_load=1 in state 2.
- REQ-040 Operation=0x23 -> State 1,2,3,4,5,6,1; RegWrite=1 with MemtoReg=1 only in state 6.
- REQ-041 Operation=0x00, Funct=0x20, ALU_overflow=1 in R_EXEC -> macro defined: State 8,14,1, PCSource=11, pc_load=1, RegWrite never 1; macro undefined: State 8,9, RegWrite=1.
- REQ-042 Operation=0x04 with ALU_zero=0 in BRANCH -> pc_load=0; with ALU_zero=1 -> pc_load=1, PCSource=01.
- REQ-043 Operation=0x2B, reset_n=0 during MEM_WR -> mem_write=0 that cycle, next State 0.
- REQ-044 Operation=0x3F -> State 3,1; RegWrite, mem_write and a_load after DECODE remain 0.
